// File: rtl/sdram_arb_pkg.sv
// sdram_arb_pkg: shared encodings for the SDRAM command arbiter.
// Holds controller command codes, arbiter FSM states and requester ids.
package sdram_arb_pkg;

    typedef enum logic [1:0] {
        CMD_RD  = 2'b00,
        CMD_WR  = 2'b01,
        CMD_REF = 2'b10
    } cmd_e;

    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } state_e;

    localparam logic PORT_M0 = 1'b0;
    localparam logic PORT_M1 = 1'b1;

endpackage

// File: rtl/sdram_tag_fifo.sv
// sdram_tag_fifo: DEPTH x 1-bit FIFO of requester ids for outstanding reads.
// Ports: push_i/din_i write side, pop_i read side, dout_o head, full_o/empty_o.
module sdram_tag_fifo #(
    parameter int DEPTH = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic push_i,
    input  logic din_i,
    input  logic pop_i,
    output logic dout_o,
    output logic full_o,
    output logic empty_o
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DEPTH-1:0] mem_q;
    logic [PW-1:0]    wp_q;
    logic [PW-1:0]    rp_q;
    logic [PW:0]      cnt_q;
    logic             do_push;
    logic             do_pop;

    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == (PW+1)'(DEPTH));
    assign dout_o  = mem_q[rp_q];

    // A pop in the same cycle frees the slot, so a full FIFO still takes a push.
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_ff @(posedge clk) begin
        if (!rst) begin
            mem_q <= '0;
            wp_q  <= '0;
            rp_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) begin
                mem_q[wp_q] <= din_i;
                wp_q        <= wp_q + 1'b1;
            end
            if (do_pop) begin
                rp_q <= rp_q + 1'b1;
            end
            unique case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

endmodule

// File: rtl/sdram_arb.sv
// sdram_arb: shares one SDRAM controller command port between m0 and m1,
// schedules auto-refresh and routes read data back in issue order.
// Ports: mX_* requester side (req/we/addr/wdata in, gnt/rvalid/rdata out),
// c_* controller side, ref_overrun / rsp_err sticky error flags.
module sdram_arb
    import sdram_arb_pkg::*;
#(
    parameter int AW           = 24,
    parameter int DW           = 16,
    parameter int REF_INTERVAL = 780,
    parameter int REF_MAX_DEBT = 4,
    parameter int RSP_DEPTH    = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          m0_req,
    input  logic          m0_we,
    input  logic [AW-1:0] m0_addr,
    input  logic [DW-1:0] m0_wdata,
    output logic          m0_gnt,
    output logic          m0_rvalid,
    output logic [DW-1:0] m0_rdata,
    input  logic          m1_req,
    input  logic          m1_we,
    input  logic [AW-1:0] m1_addr,
    input  logic [DW-1:0] m1_wdata,
    output logic          m1_gnt,
    output logic          m1_rvalid,
    output logic [DW-1:0] m1_rdata,
    output logic          c_valid,
    input  logic          c_ready,
    output logic [1:0]    c_cmd,
    output logic [AW-1:0] c_addr,
    output logic [DW-1:0] c_wdata,
    input  logic          c_rvalid,
    input  logic [DW-1:0] c_rdata,
    output logic          ref_overrun,
    output logic          rsp_err
);

    localparam int TW  = (REF_INTERVAL > 1) ? $clog2(REF_INTERVAL) : 1;
    localparam int DBW = $clog2(REF_MAX_DEBT + 1);

    state_e          state_q, state_d;
    cmd_e            cmd_q, cmd_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [DW-1:0]   wdata_q, wdata_d;
    logic            own_q, own_d;
    logic            rr_q, rr_d;
    logic [TW-1:0]   tmr_q;
    logic [DBW-1:0]  debt_q, debt_d;
    logic            ovr_q, ovr_d;
    logic            err_q;
    logic            m0_rv_q, m1_rv_q;
    logic [DW-1:0]   m0_rd_q, m1_rd_q;

    logic            fifo_full, fifo_empty, fifo_head;
    logic            hs, is_ref, wrap, ref_acc, rd_acc;
    logic            elig0, elig1, win1;
    logic            rsp_ok;

    // Reset low kills the in-flight handshake so no grant leaks out.
    assign hs      = (state_q == ISSUE) && c_ready && rst;
    assign is_ref  = (cmd_q == CMD_REF);
    assign ref_acc = hs && is_ref;
    assign rd_acc  = hs && (cmd_q == CMD_RD);
    assign wrap    = (tmr_q == TW'(REF_INTERVAL - 1));

    // Reads need a free tag slot; writes never wait on the FIFO.
    assign elig0 = m0_req && (m0_we || !fifo_full);
    assign elig1 = m1_req && (m1_we || !fifo_full);
    assign win1  = elig1 && (!elig0 || (rr_q == PORT_M1));

    assign rsp_ok = c_rvalid && !fifo_empty;

    always_comb begin
        state_d = state_q;
        cmd_d   = cmd_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        own_d   = own_q;
        rr_d    = rr_q;
        unique case (state_q)
            IDLE: begin
                if (debt_q != '0) begin
                    cmd_d   = CMD_REF;
                    addr_d  = '0;
                    wdata_d = '0;
                    own_d   = PORT_M0;
                    state_d = ISSUE;
                end else if (elig0 || elig1) begin
                    own_d   = win1 ? PORT_M1 : PORT_M0;
                    cmd_d   = (win1 ? m1_we : m0_we) ? CMD_WR : CMD_RD;
                    addr_d  = win1 ? m1_addr : m0_addr;
                    wdata_d = win1 ? m1_wdata : m0_wdata;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (hs) begin
                    state_d = IDLE;
                    // Last granted requester drops to lowest priority.
                    if (!is_ref) begin
                        rr_d = ~own_q;
                    end
                end
            end
        endcase
    end

    always_comb begin
        debt_d = debt_q;
        ovr_d  = ovr_q;
        unique case ({wrap, ref_acc})
            2'b10: begin
                if (debt_q == DBW'(REF_MAX_DEBT)) begin
                    ovr_d = 1'b1;
                end else begin
                    debt_d = debt_q + 1'b1;
                end
            end
            2'b01:   debt_d = debt_q - 1'b1;
            default: debt_d = debt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            cmd_q   <= CMD_RD;
            addr_q  <= '0;
            wdata_q <= '0;
            own_q   <= PORT_M0;
            rr_q    <= PORT_M0;
            tmr_q   <= '0;
            debt_q  <= '0;
            ovr_q   <= 1'b0;
            err_q   <= 1'b0;
            m0_rv_q <= 1'b0;
            m1_rv_q <= 1'b0;
            m0_rd_q <= '0;
            m1_rd_q <= '0;
        end else begin
            state_q <= state_d;
            cmd_q   <= cmd_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            own_q   <= own_d;
            rr_q    <= rr_d;
            tmr_q   <= wrap ? '0 : tmr_q + 1'b1;
            debt_q  <= debt_d;
            ovr_q   <= ovr_d;
            err_q   <= err_q | (c_rvalid && fifo_empty);
            m0_rv_q <= rsp_ok && (fifo_head == PORT_M0);
            m1_rv_q <= rsp_ok && (fifo_head == PORT_M1);
            if (rsp_ok && (fifo_head == PORT_M0)) begin
                m0_rd_q <= c_rdata;
            end
            if (rsp_ok && (fifo_head == PORT_M1)) begin
                m1_rd_q <= c_rdata;
            end
        end
    end

    sdram_tag_fifo #(
        .DEPTH (RSP_DEPTH)
    ) u_tag_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (rd_acc),
        .din_i   (own_q),
        .pop_i   (c_rvalid),
        .dout_o  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign c_valid     = (state_q == ISSUE) && rst;
    assign c_cmd       = cmd_q;
    assign c_addr      = addr_q;
    assign c_wdata     = wdata_q;
    assign m0_gnt      = hs && !is_ref && (own_q == PORT_M0);
    assign m1_gnt      = hs && !is_ref && (own_q == PORT_M1);
    assign m0_rvalid   = m0_rv_q;
    assign m1_rvalid   = m1_rv_q;
    assign m0_rdata    = m0_rd_q;
    assign m1_rdata    = m1_rd_q;
    assign ref_overrun = ovr_q;
    assign rsp_err     = err_q;

endmodule

// File: tb/tb_sdram_arb.sv
// tb_sdram_arb: self-checking bench for sdram_arb.
// Read returns are checked against a queue of expected port/data pairs.
module tb_sdram_arb;

    localparam int AW = 24;
    localparam int DW = 16;
    localparam int RI = 780;

    logic          clk = 1'b0;
    logic          rst;
    logic          m0_req, m0_we, m0_gnt, m0_rvalid;
    logic [AW-1:0] m0_addr;
    logic [DW-1:0] m0_wdata, m0_rdata;
    logic          m1_req, m1_we, m1_gnt, m1_rvalid;
    logic [AW-1:0] m1_addr;
    logic [DW-1:0] m1_wdata, m1_rdata;
    logic          c_valid, c_ready, c_rvalid;
    logic [1:0]    c_cmd;
    logic [AW-1:0] c_addr;
    logic [DW-1:0] c_wdata, c_rdata;
    logic          ref_overrun, rsp_err;

    typedef struct packed {
        logic          port;
        logic [DW-1:0] data;
    } rsp_t;

    rsp_t          sb[$];
    rsp_t          exp_r;
    logic          got_p;
    logic [DW-1:0] got_d;
    int            errors = 0;
    int            checks = 0;
    int            g0 = 0;
    int            g1 = 0;

    always #5 clk = ~clk;

    sdram_arb dut (
        .clk         (clk),
        .rst         (rst),
        .m0_req      (m0_req),
        .m0_we       (m0_we),
        .m0_addr     (m0_addr),
        .m0_wdata    (m0_wdata),
        .m0_gnt      (m0_gnt),
        .m0_rvalid   (m0_rvalid),
        .m0_rdata    (m0_rdata),
        .m1_req      (m1_req),
        .m1_we       (m1_we),
        .m1_addr     (m1_addr),
        .m1_wdata    (m1_wdata),
        .m1_gnt      (m1_gnt),
        .m1_rvalid   (m1_rvalid),
        .m1_rdata    (m1_rdata),
        .c_valid     (c_valid),
        .c_ready     (c_ready),
        .c_cmd       (c_cmd),
        .c_addr      (c_addr),
        .c_wdata     (c_wdata),
        .c_rvalid    (c_rvalid),
        .c_rdata     (c_rdata),
        .ref_overrun (ref_overrun),
        .rsp_err     (rsp_err)
    );

    always @(negedge clk) begin
        if (m0_gnt) g0++;
        if (m1_gnt) g1++;
        if (m0_rvalid || m1_rvalid) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL rsp_route unexpected rvalid m0=%b m1=%b, want none",
                         m0_rvalid, m1_rvalid);
            end else begin
                exp_r = sb.pop_front();
                got_p = m1_rvalid;
                got_d = m1_rvalid ? m1_rdata : m0_rdata;
                if ((m0_rvalid && m1_rvalid) || got_p !== exp_r.port ||
                    got_d !== exp_r.data) begin
                    errors++;
                    $display("FAIL rsp_route got port=%0d data=%h, want port=%0d data=%h",
                             got_p, got_d, exp_r.port, exp_r.data);
                end
            end
        end
    end

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        m0_req = 0; m0_we = 0; m0_addr = '0; m0_wdata = '0;
        m1_req = 0; m1_we = 0; m1_addr = '0; m1_wdata = '0;
        c_ready = 0; c_rvalid = 0; c_rdata = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
    endtask

    task automatic issue(input bit p, input bit we, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, output bit ok);
        ok = 1'b0;
        if (!p) begin
            m0_req = 1; m0_we = we; m0_addr = a; m0_wdata = d;
        end else begin
            m1_req = 1; m1_we = we; m1_addr = a; m1_wdata = d;
        end
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            ok = p ? m1_gnt : m0_gnt;
        end
        @(posedge clk);
        #1;
        if (!p) m0_req = 0;
        else    m1_req = 0;
    endtask

    task automatic send_rsp(input bit p, input logic [DW-1:0] d);
        rsp_t e;
        @(posedge clk);
        #1;
        c_rvalid = 1'b1;
        c_rdata  = d;
        e.port   = p;
        e.data   = d;
        sb.push_back(e);
        @(posedge clk);
        #1 c_rvalid = 1'b0;
        @(negedge clk);
        checks++;
        if ((p ? m1_rvalid : m0_rvalid) !== 1'b1) begin
            errors++;
            $display("FAIL rsp_latency port=%0d rvalid=%b, want 1", p,
                     p ? m1_rvalid : m0_rvalid);
        end
    endtask

    task automatic test_reset();
        logic [6:0] flags;
        rst = 1'b0;
        c_ready = 1; c_rvalid = 0; c_rdata = '0;
        m0_req = 0; m0_we = 0; m0_addr = '0; m0_wdata = '0;
        m1_req = 0; m1_we = 0; m1_addr = '0; m1_wdata = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        flags = {c_valid, m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, ref_overrun, rsp_err};
        checks++;
        if (flags !== 7'b0) begin
            errors++;
            $display("FAIL reset_flags got=%b want=0000000", flags);
        end
        checks++;
        if ({c_cmd, c_addr, c_wdata, m0_rdata, m1_rdata} !== '0) begin
            errors++;
            $display("FAIL reset_data got cmd=%b addr=%h wdata=%h r0=%h r1=%h, want 0",
                     c_cmd, c_addr, c_wdata, m0_rdata, m1_rdata);
        end
        @(posedge clk);
        #1 rst = 1'b1;
    endtask

    task automatic test_write();
        int g0s;
        do_reset();
        g0s = g0;
        m0_req = 1; m0_we = 1; m0_addr = 24'h000123; m0_wdata = 16'hBEEF;
        c_ready = 1;
        @(negedge clk);
        checks++;
        if (c_valid !== 1'b0) begin
            errors++;
            $display("FAIL wr_cvalid_early got=%b want=0", c_valid);
        end
        @(negedge clk);
        checks++;
        if ({c_valid, c_cmd, c_addr, c_wdata} !== {1'b1, 2'b01, 24'h000123, 16'hBEEF}) begin
            errors++;
            $display("FAIL wr_cmd got v=%b cmd=%b addr=%h wdata=%h, want 1 01 000123 beef",
                     c_valid, c_cmd, c_addr, c_wdata);
        end
        checks++;
        if ({m0_gnt, m1_gnt} !== 2'b10) begin
            errors++;
            $display("FAIL wr_gnt got=%b%b want=10", m0_gnt, m1_gnt);
        end
        @(posedge clk);
        #1 m0_req = 0;
        @(negedge clk);
        checks++;
        if ({c_valid, m0_gnt} !== 2'b00) begin
            errors++;
            $display("FAIL wr_release got v=%b gnt=%b want 0 0", c_valid, m0_gnt);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (g0 - g0s !== 1) begin
            errors++;
            $display("FAIL wr_gnt_count got=%0d want=1", g0 - g0s);
        end
    endtask

    task automatic test_alternate();
        logic [3:0] seq;
        int         n;
        do_reset();
        seq = '0;
        n   = 0;
        c_ready = 1;
        m0_req = 1; m0_we = 0; m0_addr = 24'h010000;
        m1_req = 1; m1_we = 0; m1_addr = 24'h020000;
        for (int i = 0; i < 40 && n < 4; i++) begin
            @(negedge clk);
            if (m0_gnt && n < 4) begin seq = {seq[2:0], 1'b0}; n++; end
            if (m1_gnt && n < 4) begin seq = {seq[2:0], 1'b1}; n++; end
        end
        @(posedge clk);
        #1;
        m0_req = 0;
        m1_req = 0;
        checks++;
        if (n !== 4 || seq !== 4'b0101) begin
            errors++;
            $display("FAIL rr_order got n=%0d seq=%b want n=4 seq=0101", n, seq);
        end
        for (int k = 0; k < 4; k++) begin
            send_rsp(k[0], DW'(16'h1111 * (k + 1)));
        end
        repeat (2) @(negedge clk);
        checks++;
        if ({m0_rdata, m1_rdata} !== {16'h3333, 16'h4444}) begin
            errors++;
            $display("FAIL rdata_hold got r0=%h r1=%h want 3333 4444", m0_rdata, m1_rdata);
        end
        checks++;
        if (sb.size() !== 0) begin
            errors++;
            $display("FAIL alt_drain pending=%0d want=0", sb.size());
        end
    endtask

    task automatic test_stall();
        do_reset();
        m1_req = 1; m1_we = 1; m1_addr = 24'h0ABCDE; m1_wdata = 16'h5A5A;
        c_ready = 0;
        @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            checks++;
            if ({c_valid, c_cmd, c_addr, c_wdata, m0_gnt, m1_gnt} !==
                {1'b1, 2'b01, 24'h0ABCDE, 16'h5A5A, 2'b00}) begin
                errors++;
                $display("FAIL stall_hold cyc=%0d got v=%b cmd=%b addr=%h wd=%h gnt=%b%b",
                         k, c_valid, c_cmd, c_addr, c_wdata, m0_gnt, m1_gnt);
            end
        end
        @(posedge clk);
        #1 c_ready = 1;
        @(negedge clk);
        checks++;
        if ({c_valid, m1_gnt, m0_gnt} !== 3'b110) begin
            errors++;
            $display("FAIL stall_release got v=%b g1=%b g0=%b want 1 1 0",
                     c_valid, m1_gnt, m0_gnt);
        end
        @(posedge clk);
        #1 m1_req = 0;
        @(negedge clk);
        checks++;
        if (c_valid !== 1'b0) begin
            errors++;
            $display("FAIL stall_done c_valid=%b want=0", c_valid);
        end
    endtask

    task automatic test_fifo_full();
        bit ok;
        bit seen;
        int n0;
        int n1;
        do_reset();
        c_ready = 1;
        for (int k = 0; k < 3; k++) begin
            issue(1'b0, 1'b0, AW'(24'h000100 + k), '0, ok);
            checks++;
            if (!ok) begin
                errors++;
                $display("FAIL ff_fill_m0 idx=%0d gnt=0 want=1", k);
            end
        end
        issue(1'b1, 1'b0, 24'h000200, '0, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL ff_fill_m1 gnt=0 want=1");
        end
        n0 = 0;
        n1 = 0;
        m0_req = 1; m0_we = 0; m0_addr = 24'h000300;
        m1_req = 1; m1_we = 1; m1_addr = 24'h000400; m1_wdata = 16'h7777;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            seen = m1_gnt;
            if (m0_gnt) n0++;
            if (m1_gnt) n1++;
            @(posedge clk);
            #1;
            if (seen) m1_req = 0;
        end
        checks++;
        if (n0 !== 0 || n1 !== 1) begin
            errors++;
            $display("FAIL ff_block got m0_gnts=%0d m1_gnts=%0d want 0 1", n0, n1);
        end
        send_rsp(1'b0, 16'hA001);
        seen = 1'b0;
        ok   = 1'b0;
        for (int i = 0; i < 12 && !seen; i++) begin
            @(negedge clk);
            if (m0_gnt) begin
                seen = 1'b1;
                ok   = (c_cmd == 2'b00) && (c_addr == 24'h000300);
            end
        end
        @(posedge clk);
        #1 m0_req = 0;
        checks++;
        if (!seen || !ok) begin
            errors++;
            $display("FAIL ff_unblock got gnt=%b cmd_ok=%b want 1 1", seen, ok);
        end
        send_rsp(1'b0, 16'hA002);
        send_rsp(1'b0, 16'hA003);
        send_rsp(1'b1, 16'hB001);
        send_rsp(1'b0, 16'hA004);
        repeat (2) @(negedge clk);
        checks++;
        if (sb.size() !== 0 || rsp_err !== 1'b0) begin
            errors++;
            $display("FAIL ff_drain pending=%0d rsp_err=%b want 0 0", sb.size(), rsp_err);
        end
    endtask

    task automatic test_rsp_err_reset();
        int g0s;
        do_reset();
        c_rvalid = 1;
        c_rdata  = 16'hDEAD;
        @(posedge clk);
        #1 c_rvalid = 0;
        @(negedge clk);
        checks++;
        if ({rsp_err, m0_rvalid, m1_rvalid} !== 3'b100) begin
            errors++;
            $display("FAIL rsp_err got err=%b rv0=%b rv1=%b want 1 0 0",
                     rsp_err, m0_rvalid, m1_rvalid);
        end
        g0s = g0;
        @(posedge clk);
        #1;
        m0_req = 1; m0_we = 1; m0_addr = 24'h0000AA; m0_wdata = 16'h1234;
        c_ready = 0;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (c_valid !== 1'b1) begin
            errors++;
            $display("FAIL rst_setup c_valid=%b want=1", c_valid);
        end
        @(posedge clk);
        #1;
        rst = 0;
        c_ready = 1;
        @(negedge clk);
        checks++;
        if ({m0_gnt, m1_gnt} !== 2'b00) begin
            errors++;
            $display("FAIL rst_no_gnt got=%b%b want=00", m0_gnt, m1_gnt);
        end
        @(negedge clk);
        checks++;
        if ({c_valid, c_cmd, c_addr, c_wdata, m0_gnt, m1_gnt, m0_rvalid, m1_rvalid,
             ref_overrun, rsp_err} !== '0) begin
            errors++;
            $display("FAIL rst_outputs v=%b cmd=%b addr=%h wd=%h err=%b want all 0",
                     c_valid, c_cmd, c_addr, c_wdata, rsp_err);
        end
        @(posedge clk);
        #1;
        m0_req = 0;
        rst = 1;
        repeat (3) @(negedge clk);
        checks++;
        if (g0 !== g0s) begin
            errors++;
            $display("FAIL rst_gnt_count got=%0d want=%0d", g0, g0s);
        end
    endtask

    task automatic test_refresh();
        int nref;
        bit bad;
        do_reset();
        c_ready = 1;
        nref = 0;
        bad  = 1'b0;
        for (int i = 1; i <= RI + 20; i++) begin
            @(negedge clk);
            if (c_valid && c_ready && c_cmd == 2'b10) begin
                nref++;
                if (c_addr !== '0 || c_wdata !== '0) bad = 1'b1;
            end
        end
        checks++;
        if (nref !== 1 || bad) begin
            errors++;
            $display("FAIL ref_once got count=%0d bad_fields=%b want 1 0", nref, bad);
        end
        checks++;
        if (dut.debt_q !== 3'd0 || c_valid !== 1'b0) begin
            errors++;
            $display("FAIL ref_debt0 got debt=%0d v=%b want 0 0", dut.debt_q, c_valid);
        end
        @(posedge clk);
        #1 c_ready = 0;
        repeat (2400) @(negedge clk);
        checks++;
        if (ref_overrun !== 1'b0 || dut.debt_q !== 3'd3) begin
            errors++;
            $display("FAIL ref_debt3 got ovr=%b debt=%0d want 0 3", ref_overrun, dut.debt_q);
        end
        repeat (1520) @(negedge clk);
        checks++;
        if (ref_overrun !== 1'b1 || dut.debt_q !== 3'd4) begin
            errors++;
            $display("FAIL ref_overrun got ovr=%b debt=%0d want 1 4", ref_overrun, dut.debt_q);
        end
        checks++;
        if ({c_valid, c_cmd} !== 3'b110) begin
            errors++;
            $display("FAIL ref_held got v=%b cmd=%b want 1 10", c_valid, c_cmd);
        end
        @(posedge clk);
        #1 c_ready = 1;
        repeat (20) @(negedge clk);
        checks++;
        if (ref_overrun !== 1'b1) begin
            errors++;
            $display("FAIL ref_sticky got=%b want=1", ref_overrun);
        end
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 0;
        m0_req = 0; m0_we = 0; m0_addr = '0; m0_wdata = '0;
        m1_req = 0; m1_we = 0; m1_addr = '0; m1_wdata = '0;
        c_ready = 0; c_rvalid = 0; c_rdata = '0;
        test_reset();
        test_write();
        test_alternate();
        test_stall();
        test_fifo_full();
        test_rsp_err_reset();
        test_refresh();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sdram_arb.md
Name: sdram_arb

Overview:
Shares the single SDRAM controller command interface between two requesters: m0 (physics update engine) and m1 (readback/display path). It also schedules the periodic auto-refresh. Read data returning from the controller is routed back to the requester that issued the read, in issue order. The block sits directly upstream of the SDRAM controller.

Parameters:
AW, 24, command address width: {ba[1:0], row[12:0], col[8:0]}
DW, 16, data width
REF_INTERVAL, 780, clk cycles per refresh (7.8 us at 100 MHz)
REF_MAX_DEBT, 4, maximum refreshes owed before overrun is flagged
RSP_DEPTH, 4, maximum outstanding reads (tag FIFO depth, power of 2)

Ports:
clk  in  1  system clock, 100 MHz
rst  in  1  synchronous, active-low reset
m0_req  in  1  request; held with fields stable until m0_gnt
m0_we  in  1  1 = write, 0 = read
m0_addr  in  AW  address
m0_wdata  in  DW  write data
m0_gnt  out  1  one-cycle pulse: command accepted by controller
m0_rvalid  out  1  one-cycle pulse: read data valid
m0_rdata  out  DW  read data
m1_*  same six signals as m0_*, for requester 1
c_valid  out  1  command valid to controller
c_ready  in  1  controller accepts command
c_cmd  out  2  00 read, 01 write, 10 refresh
c_addr  out  AW  command address
c_wdata  out  DW  command write data
c_rvalid  in  1  read data from controller valid
c_rdata  in  DW  read data from controller
ref_overrun  out  1  sticky: refresh debt saturated
rsp_err  out  1  sticky: c_rvalid received with no outstanding read

Behaviour:
- Reset (rst=0 at a clk edge): all outputs 0, FSM in IDLE, refresh timer 0, refresh debt 0, round-robin pointer favours m0, tag FIFO empty. A reset during ISSUE abandons the in-flight command; no gnt is given.
- FSM IDLE: pick a winner using the rules below, latch its cmd/addr/wdata into the c_* registers, then go to ISSUE. c_valid rises the cycle after the request is seen. If there is no eligible winner, stay in IDLE.
- FSM ISSUE: c_valid=1 and c_* are held stable. On c_valid&&c_ready in a cycle:
  - pulse the winner's mX_gnt in that same cycle;
  - deassert c_valid on the next cycle;
  - return to IDLE.
  - Result: at most one command every 2 cycles.
- Arbitration priority:
  - Refresh: wins whenever debt>0, with c_addr=0 and c_wdata=0.
  - Otherwise round-robin between m0 and m1. The pointer updates only on an accepted handshake, so the last-granted requester becomes lowest priority.
  - A read is eligible only if the tag FIFO is not full. A write is always eligible.
  - If m0 holds a read blocked by a full FIFO and m1 has a write, m1 is granted.
- Requester rules:
  - A request must not be withdrawn before gnt.
  - Once latched, a command is issued regardless of mX_req.
  - A requester sees at most one gnt per command.
- Tag FIFO:
  - Push the port id on each accepted read.
  - Pop on c_rvalid.
  - A simultaneous push and pop is legal, including when the FIFO is full.
- Read return: on c_rvalid, route c_rdata to the head port.
  - mX_rvalid/mX_rdata are registered: 1 cycle after c_rvalid.
  - Non-selected rdata holds its last value.
  - c_rvalid with an empty FIFO: data is dropped and rsp_err is set.
- Refresh timer:
  - Counts 0..REF_INTERVAL-1 and wraps.
  - On wrap: debt+1.
  - On accepted refresh: debt-1.
  - Wrap and accept in the same cycle: debt is unchanged.
  - Wrap with debt==REF_MAX_DEBT (and no accept): debt stays saturated and ref_overrun is set.
- Sticky flags clear only on reset.

Decomposition:
- Package sdram_arb_pkg: c_cmd encodings (CMD_RD, CMD_WR, CMD_REF), FSM state encodings (IDLE, ISSUE), port id constants (PORT_M0, PORT_M1).
- One sub-module, sdram_tag_fifo: RSP_DEPTH x 1-bit synchronous FIFO with full/empty flags and simultaneous push/pop.

Test Plan:
1. Reset, then m0 write addr=0x000123 wdata=0xBEEF with c_ready=1: c_valid at cycle+1, c_cmd=01, c_addr=0x000123; m0_gnt pulses once in the same cycle.
2. m0 and m1 both request reads continuously with c_ready=1: grants alternate m0,m1,m0,m1. Controller returns 0x1111 then 0x2222: m0_rdata=0x1111 and m1_rdata=0x2222, each 1 cycle after c_rvalid.
3. Hold c_ready=0 during ISSUE for 5 cycles: c_valid and c_* stay stable; no gnt until c_ready=1.
4. Idle for REF_INTERVAL cycles: c_cmd=10 is issued once and debt returns to 0. Hold c_ready=0 for 5*REF_INTERVAL cycles: ref_overrun=1.
5. Issue 4 m0 reads with no returns, then m0 read + m1 write: m1 write is granted and m0 stalls. One c_rvalid pops the FIFO and m0's read is then granted.
6. c_rvalid with no outstanding reads: rsp_err=1 and no mX_rvalid. Pull rst=0 mid-ISSUE: all outputs are 0 on the next edge and no gnt is given.
